// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: computes a WIDTH-bit add or subtract over NIB = WIDTH/4
// cycles. A single 4-bit carry-lookahead slice is reused, one nibble per cycle,
// LSB nibble first. The slice carry-out is held in a register between nibbles.
// Optional feature macro: NIBBLE_ADDER_SEQ_FLAGS_EN adds the zero/ovf flag ports.

// 4-bit carry-lookahead adder slice
module nibble_adder_seq_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is flattened in terms of generate/propagate and the carry-in
  always_comb begin
    w_c[0] = i_c;
    w_c[1] = w_g[0] | (w_p[0] & i_c);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_c);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
  end

  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module nibble_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_ovf
`endif
);
  localparam int NIB = WIDTH / 4;
  // The counter keeps at least one bit so that WIDTH = 4 still elaborates
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic [3:0]       w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  nibble_adder_seq_cla4 u_cla (
    .i_a (r_a[3:0]),
    .i_b (r_b[3:0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // New nibble enters the result from the top; WIDTH = 4 has nothing to shift
  generate
    if (NIB > 1) begin : g_shift
      assign w_sum_next = {w_s, r_sum[WIDTH-1:4]};
    end else begin : g_single
      assign w_sum_next = w_s;
    end
  endgenerate

`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
  logic r_zero;
  logic r_ovf;
`endif

  // Sequencer FSM: accept operands, run one nibble per cycle, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_cnt       <= '0;
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            // Subtract is A + ~B + 1; the external carry-in is ignored then
            r_a        <= i_a;
            r_b        <= i_sub ? ~i_b : i_b;
            r_carry    <= i_sub ? 1'b1 : i_cin;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_cout      <= w_c;
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
            // The operand MSBs sit in bit 3 of the shift registers right now
            r_zero      <= (w_sum_next == '0);
            r_ovf       <= (r_a[3] == r_b[3]) & (w_s[3] != r_a[3]);
`endif
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
  assign o_zero      = r_zero;
  assign o_ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_adder_seq.sv
// Directed, table-driven bench for nibble_adder_seq at WIDTH = 16.
// Flag checks are compiled in only when NIBBLE_ADDER_SEQ_FLAGS_EN is defined.
module tb_nibble_adder_seq;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_adder_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_sub       (sub),
    .i_cin       (cin),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout)
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
    ,
    .o_zero      (zero),
    .o_ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: wait for in_ready, issue, measure latency, drain.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '1; b = '1; sub = ~v.sub; cin = ~v.cin;
    check({tag, " in_ready low in RUN"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " sum"}, 32'(sum), 32'(v.s));
    check({tag, " cout"}, 32'(cout), 32'(v.co));
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
    check({tag, " zero"}, 32'(zero), 32'(v.z));
    check({tag, " ovf"}, 32'(ovf), 32'(v.v));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after drain"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after drain"}, 32'(in_ready), 32'd1);
    $display("op %s: a=%04h b=%04h sub=%0d cin=%0d -> sum=%04h cout=%0d lat=%0d",
             tag, v.a, v.b, v.sub, v.cin, v.s, v.co, n);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    vec_t         t;
    int           n;

    //           a        b        sub   cin   sum      co    z     v
    vecs[0]  = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
    check("reset zero", 32'(zero), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while in_valid pulses are ignored
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("bp latency", 32'(n), 32'd4);
    check("bp sum", 32'(sum), 32'h3333);
    held_sum = sum; held_cout = cout;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; a = 16'hDEAD; b = 16'hBEEF;
      @(posedge clk); #1;
      check("bp sum hold", 32'(sum), 32'(held_sum));
      check("bp cout hold", 32'(cout), 32'(held_cout));
      check("bp out_valid hold", 32'(out_valid), 32'd1);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp out_valid drop", 32'(out_valid), 32'd0);
    check("bp in_ready rise", 32'(in_ready), 32'd1);
    $display("op backpressure: 1111+2222 -> sum=%04h held 5 cycles", held_sum);

    // Back-to-back operations after the stall stay independent
    t = '{16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b0};
    run_op(t, "b2b0");
    t = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    run_op(t, "b2b1");

    // Reset during the second RUN cycle discards the operation
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst in_ready", 32'(in_ready), 32'd1);
    check("mid-rst sum", 32'(sum), 32'd0);
    check("mid-rst cout", 32'(cout), 32'd0);
    $display("op reset: asserted in RUN, sum=%04h in_ready=%0d", sum, in_ready);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    t = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    run_op(t, "post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
